prog_fsm: RTL and testbench

Serially programmed jump-table state machine, the parametrised successor of the team's 5-state lattice FSM. A transition table (per state: trigger code and jump target) is shifted in one bit per clock into a shadow register and atomically committed. The machine then walks the table against a parallel input bus. An optional serial readback port shifts the live table back out for chip-level verification. It sits between the pad-level serial loader and the output mux, replacing the fixed SIPO/FSM/PISO trio.

---
 rtl/prog_fsm_pkg.sv | 31 +++
 rtl/prog_fsm_piso.sv | 51 +++++
 rtl/prog_fsm.sv | 142 ++++++++++++++
 tb/tb_prog_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_fsm_pkg.sv
// prog_fsm_pkg
// Shared definitions for the serially programmed jump-table FSM:
// default geometry, the run-mode enum, and the helpers that compute the
// configuration frame length and the bit offsets of each state's fields
// inside the committed table.
package prog_fsm_pkg;

  localparam int N_STATES_DEF = 5;
  localparam int IN_W_DEF     = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no frame committed since reset
    ST_RUN  = 1'b1   // table live, walking against the input bus
  } run_mode_e;

  // Total configuration frame length in bits.
  function automatic int calc_frame_w(input int n_states, input int in_w);
    return n_states * (in_w + $clog2(n_states));
  endfunction

  // State 0 is shifted in first, so it ends up in the most significant
  // slot; within a slot TRIG sits above JUMP.
  function automatic int jump_lsb(input int idx, input int n_states, input int in_w);
    return calc_frame_w(n_states, in_w) - (idx + 1) * (in_w + $clog2(n_states));
  endfunction

  function automatic int trig_lsb(input int idx, input int n_states, input int in_w);
    return jump_lsb(idx, n_states, in_w) + $clog2(n_states);
  endfunction

endpackage

// File: rtl/prog_fsm_piso.sv
// prog_fsm_piso
// Generic parallel-load, MSB-first shift-out register.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   i_load  - load i_data when idle (ignored while busy)
//   i_data  - parallel word, W bits
//   o_busy  - high for exactly W cycles after a load
//   o_dout  - serial data; MSB appears in the first busy cycle
module prog_fsm_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_busy,
  output logic         o_dout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_load && !r_busy) begin
      r_shift <= i_data;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == CW'(W - 1)) begin
        // Clearing the shifter returns the serial line to 0 when idle.
        r_busy  <= 1'b0;
        r_shift <= '0;
      end else begin
        r_shift <= {r_shift[W-2:0], 1'b0};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_dout = r_shift[W-1];

endmodule

// File: rtl/prog_fsm.sv
// prog_fsm
// Serially programmed jump-table state machine. A table of
// (trigger, jump) pairs per state is shifted in MSB first, committed
// atomically on its last bit, then walked against the parallel input.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   cfg_en   - cfg_bit valid this cycle
//   cfg_bit  - serial configuration data, state 0 first, MSB first
//   in       - run-time input code
//   state    - current state index
//   match    - pulse, one cycle after a taken transition
//   cfg_ok   - a frame has been committed since reset
//   rb_start - start serial readback of the live table
//   rb_busy  - readback in progress
//   rb_out   - serial readback data
// Build option: PROG_FSM_READBACK_EN enables the readback shifter; without
// it rb_start is ignored and rb_busy/rb_out are tied to 0.
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter int N_STATES = N_STATES_DEF,
  parameter int IN_W     = IN_W_DEF,
  parameter int STATE_W  = $clog2(N_STATES),
  parameter int FRAME_W  = calc_frame_w(N_STATES, IN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic               cfg_bit,
  input  logic [IN_W-1:0]    in,
  output logic [STATE_W-1:0] state,
  output logic               match,
  output logic               cfg_ok,
  input  logic               rb_start,
  output logic               rb_busy,
  output logic               rb_out
);

  localparam int BCNT_W = $clog2(FRAME_W + 1);

  // The shadow only needs the first FRAME_W-1 bits: the final bit goes
  // straight from cfg_bit into the live table on the commit edge.
  logic [FRAME_W-2:0] r_shadow;
  logic [FRAME_W-1:0] r_live;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [STATE_W-1:0] r_state;
  logic               r_match;
  run_mode_e          r_mode;

  logic               w_last;
  logic [FRAME_W-1:0] w_frame;

  assign w_last  = cfg_en && (r_bcnt == BCNT_W'(FRAME_W - 1));
  assign w_frame = {r_shadow, cfg_bit};

  // Loader: shift register and bit counter; both hold while cfg_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_live   <= '0;
      r_bcnt   <= '0;
    end else if (cfg_en) begin
      r_shadow <= w_frame[FRAME_W-2:0];
      if (w_last) begin
        r_live <= w_frame;
        r_bcnt <= '0;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Per-state field views into the live table.
  logic [IN_W-1:0]    w_trig [N_STATES];
  logic [STATE_W-1:0] w_jump [N_STATES];

  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_field
    assign w_trig[gi] = r_live[trig_lsb(gi, N_STATES, IN_W) +: IN_W];
    assign w_jump[gi] = r_live[jump_lsb(gi, N_STATES, IN_W) +: STATE_W];
  end

  logic               w_hit;
  logic [STATE_W-1:0] w_cur_jump;
  logic [STATE_W-1:0] w_jump_safe;

  assign w_hit       = (in == w_trig[r_state]);
  assign w_cur_jump  = w_jump[r_state];
  // Targets beyond the last state fall back to state 0.
  assign w_jump_safe = ({1'b0, w_cur_jump} < (STATE_W + 1)'(N_STATES)) ? w_cur_jump : '0;

  // Run FSM. A commit overrides any transition in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= ST_IDLE;
      r_state <= '0;
      r_match <= 1'b0;
    end else if (w_last) begin
      r_mode  <= ST_RUN;
      r_state <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_mode)
        ST_RUN: begin
          if (w_hit) begin
            r_state <= w_jump_safe;
            r_match <= 1'b1;
          end else begin
            r_match <= 1'b0;
          end
        end
        default: begin
          r_state <= '0;
          r_match <= 1'b0;
        end
      endcase
    end
  end

  assign state  = r_state;
  assign match  = r_match;
  assign cfg_ok = (r_mode == ST_RUN);

`ifdef PROG_FSM_READBACK_EN
  prog_fsm_piso #(
    .W(FRAME_W)
  ) u_readback (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (rb_start),
    .i_data (r_live),
    .o_busy (rb_busy),
    .o_dout (rb_out)
  );
`else
  logic w_unused_rb;
  assign w_unused_rb = rb_start;
  assign rb_busy     = 1'b0;
  assign rb_out      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_fsm.sv
module tb_prog_fsm;
  localparam int N  = 5;
  localparam int IW = 5;
  localparam int SW = 3;
  localparam int FW = 40;
  localparam int SL = IW + SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_en = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          rb_start = 1'b0;
  logic [IW-1:0] in_code = '0;
  logic [SW-1:0] state;
  logic          match, cfg_ok, rb_busy, rb_out;

  always #5 clk = ~clk;

  prog_fsm #(.N_STATES(N), .IN_W(IW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_bit(cfg_bit), .in(in_code),
    .state(state), .match(match), .cfg_ok(cfg_ok),
    .rb_start(rb_start), .rb_busy(rb_busy), .rb_out(rb_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: table as integer arrays, pending frame as a bit queue.
  int m_trig [N];
  int m_jump [N];
  bit m_q [$];
  int m_state;
  bit m_match, m_cfg_ok;

  // Table to be programmed next (spec-level description).
  int g_trig [N];
  int g_jump [N];

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_match = 0; m_cfg_ok = 0;
    for (int s = 0; s < N; s++) begin m_trig[s] = 0; m_jump[s] = 0; end
  endtask

  function automatic bit frame_bit(input int k);
    int s = k / SL;
    int o = k % SL;
    if (o < IW) return bit'((g_trig[s] >> (IW - 1 - o)) & 1);
    return bit'((g_jump[s] >> (SW - 1 - (o - IW))) & 1);
  endfunction

  task automatic drive(input bit en, input bit b, input int code);
    bit commit = 0;
    cfg_en = en; cfg_bit = b; in_code = code[IW-1:0];
    @(posedge clk); #1;
    if (en) begin
      m_q.push_back(b);
      if (m_q.size() == FW) commit = 1;
    end
    if (commit) begin
      for (int s = 0; s < N; s++) begin
        m_trig[s] = 0; m_jump[s] = 0;
        for (int k = 0; k < IW; k++) m_trig[s] = m_trig[s] * 2 + int'(m_q[s*SL + k]);
        for (int k = 0; k < SW; k++) m_jump[s] = m_jump[s] * 2 + int'(m_q[s*SL + IW + k]);
      end
      m_q.delete();
      m_state = 0; m_match = 0; m_cfg_ok = 1;
    end else if (m_cfg_ok && (code % 32) == m_trig[m_state]) begin
      m_state = (m_jump[m_state] >= N) ? 0 : m_jump[m_state];
      m_match = 1;
    end else begin
      m_match = 0;
    end
  endtask

  task automatic load_table(input int code, input int last_code);
    for (int k = 0; k < FW; k++) drive(1'b1, frame_bit(k), (k == FW - 1) ? last_code : code);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({state, match, cfg_ok, rb_busy, rb_out} !== 7'b0) begin
      n_fail++; $display("FAIL reset_async got %b exp 0000000", {state, match, cfg_ok, rb_busy, rb_out});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 0);
      n_checks++;
      if ({state, match, cfg_ok} !== 5'b0) begin
        n_fail++; $display("FAIL idle_c%0d got %b exp 00000", c, {state, match, cfg_ok});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_walk();
    g_trig = '{1, 2, 3, 4, 5};
    g_jump = '{1, 2, 3, 4, 0};
    load_table(0, 0);
    n_checks++;
    if ({state, match, cfg_ok} !== 5'b00001) begin
      n_fail++; $display("FAIL walk_commit got %b exp 00001", {state, match, cfg_ok});
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, k + 1);
      n_checks++;
      if (state !== SW'((k + 1) % 5) || match !== 1'b1) begin
        n_fail++; $display("FAIL walk_step%0d got state=%0d match=%0d exp state=%0d match=1", k, state, match, (k + 1) % 5);
      end
    end
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, $urandom_range(0, 6));
      n_checks++;
      if ({state, match, cfg_ok} !== {m_state[SW-1:0], m_match, m_cfg_ok}) begin
        n_fail++; $display("FAIL walk_rand%0d got %b exp %b", c, {state, match, cfg_ok}, {m_state[SW-1:0], m_match, m_cfg_ok});
      end
    end
    $display("test_walk done");
  endtask

  task automatic test_gap();
    // Partial frame then asynchronous reset: the partial bits must be lost.
    for (int k = 0; k < 15; k++) drive(1'b1, 1'($urandom), 0);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({state, match, cfg_ok} !== 5'b0) begin
      n_fail++; $display("FAIL gap_async_rst got %b exp 00000", {state, match, cfg_ok});
    end
    model_reset();
    #2 rst = 1'b1;
    for (int s = 0; s < N; s++) begin g_trig[s] = $urandom_range(0, 31); g_jump[s] = $urandom_range(0, 4); end
    for (int k = 0; k < 20; k++) drive(1'b1, frame_bit(k), 31);
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'($urandom), 31);
      n_checks++;
      if (cfg_ok !== 1'b0) begin n_fail++; $display("FAIL gap_hold%0d got cfg_ok=%0d exp 0", c, cfg_ok); end
    end
    for (int k = 20; k < FW; k++) begin
      drive(1'b1, frame_bit(k), 31);
      n_checks++;
      if (cfg_ok !== (k == FW - 1)) begin
        n_fail++; $display("FAIL gap_bit%0d got cfg_ok=%0d exp %0d", k, cfg_ok, (k == FW - 1));
      end
    end
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL gap_state got %0d exp 0", state); end
    $display("test_gap done");
  endtask

  task automatic test_commit_wins();
    g_trig = '{1, 2, 3, 4, 5};
    g_jump = '{1, 2, 3, 4, 0};
    load_table(0, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 2);
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL cw_pre got state=%0d exp 2", state); end
    load_table(0, 3);
    n_checks++;
    if (state !== 3'd0 || match !== 1'b0) begin
      n_fail++; $display("FAIL cw_commit got state=%0d match=%0d exp 0 0", state, match);
    end
    drive(1'b0, 1'b0, 1);
    n_checks++;
    if (state !== 3'd1 || match !== 1'b1) begin
      n_fail++; $display("FAIL cw_after got state=%0d match=%0d exp 1 1", state, match);
    end
    $display("test_commit_wins done");
  endtask

  task automatic test_self_jump();
    g_trig = '{10, 17, 18, 19, 20};
    g_jump = '{7, 1, 0, 0, 0};
    load_table(0, 0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 10);
      n_checks++;
      if (state !== 3'd0 || match !== 1'b1) begin
        n_fail++; $display("FAIL oor_jump%0d got state=%0d match=%0d exp 0 1", c, state, match);
      end
    end
    drive(1'b0, 1'b0, 0);
    n_checks++;
    if (match !== 1'b0) begin n_fail++; $display("FAIL oor_nohit got match=%0d exp 0", match); end
    g_jump = '{1, 1, 0, 0, 0};
    load_table(0, 0);
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b0, 17);
    n_checks++;
    if (state !== 3'd1 || match !== 1'b1) begin
      n_fail++; $display("FAIL self_jump got state=%0d match=%0d exp 1 1", state, match);
    end
    $display("test_self_jump done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3));
      n_checks++;
      if ({state, match, cfg_ok} !== {m_state[SW-1:0], m_match, m_cfg_ok}) begin
        n_fail++; $display("FAIL rand%0d got %b exp %b", c, {state, match, cfg_ok}, {m_state[SW-1:0], m_match, m_cfg_ok});
      end
    end
    // Flush any partial frame so later tests start aligned.
    while (m_q.size() != 0) drive(1'b1, 1'b0, 0);
    $display("test_random done");
  endtask

  task automatic test_readback();
    g_trig = '{1, 2, 3, 4, 5};
    g_jump = '{1, 2, 3, 4, 0};
    for (int s = 0; s < N; s++) begin g_trig[s] = $urandom_range(0, 31); g_jump[s] = $urandom_range(0, 7); end
    load_table(0, 0);
    rb_start = 1'b1;
    drive(1'b0, 1'b0, $urandom_range(0, 31));
    rb_start = 1'b0;
`ifdef PROG_FSM_READBACK_EN
    for (int k = 0; k < FW; k++) begin
      if (k > 0) begin
        rb_start = (k == 10);
        drive(1'b0, 1'b0, $urandom_range(0, 31));
        rb_start = 1'b0;
      end
      n_checks++;
      if (rb_busy !== 1'b1 || rb_out !== frame_bit(k)) begin
        n_fail++; $display("FAIL rb_bit%0d got busy=%0d out=%0d exp busy=1 out=%0d", k, rb_busy, rb_out, frame_bit(k));
      end
      n_checks++;
      if ({state, match, cfg_ok} !== {m_state[SW-1:0], m_match, m_cfg_ok}) begin
        n_fail++; $display("FAIL rb_run%0d got %b exp %b", k, {state, match, cfg_ok}, {m_state[SW-1:0], m_match, m_cfg_ok});
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 0);
      n_checks++;
      if (rb_busy !== 1'b0 || rb_out !== 1'b0) begin
        n_fail++; $display("FAIL rb_end%0d got busy=%0d out=%0d exp 0 0", c, rb_busy, rb_out);
      end
    end
`else
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rb_busy !== 1'b0 || rb_out !== 1'b0) begin
        n_fail++; $display("FAIL rb_off%0d got busy=%0d out=%0d exp 0 0", c, rb_busy, rb_out);
      end
      drive(1'b0, 1'b0, 0);
    end
`endif
    $display("test_readback done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_walk();
    test_gap();
    test_commit_wins();
    test_self_jump();
    test_random();
    test_readback();
    do_reset();
    n_checks++;
    if ({state, match, cfg_ok} !== 5'b0) begin
      n_fail++; $display("FAIL final_reset got %b exp 00000", {state, match, cfg_ok});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
